// File: rtl/dsp_share_arb.sv
// Round-robin time-sharing of one DSP48E1 multiply-add slice among N_REQ requesters.
// Operands are registered onto the slice; an ID tag pipe tracks each in-flight result.
module dsp_share_arb #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*30-1:0]  req_a,
    input  logic [N_REQ*18-1:0]  req_b,
    input  logic [N_REQ*48-1:0]  req_c,
    input  logic [N_REQ*25-1:0]  req_d,
    output logic [29:0]          dsp_a,
    output logic [17:0]          dsp_b,
    output logic [47:0]          dsp_c,
    output logic [24:0]          dsp_d,
    output logic                 dsp_ce,
    output logic                 dsp_rst,
    input  logic [47:0]          dsp_p,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [47:0]          rsp_p,
    input  logic                 rsp_ready
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int         CW      = $clog2(LAT + 1) + 1;

    logic [0:0]     state_reg;
    logic [CW-1:0]  init_cnt_reg;
    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;
    logic           tag_valid_reg [0:LAT];
    logic [IDW-1:0] tag_id_reg    [0:LAT];

    logic [29:0]    dsp_a_reg;
    logic [17:0]    dsp_b_reg;
    logic [47:0]    dsp_c_reg;
    logic [24:0]    dsp_d_reg;

    logic           ce;
    logic           grant_found;
    logic           transfer;
    logic [IDW-1:0] winner;
    logic [IDW:0]   cand;

    // Slice is held in reset and clocked through INIT so its pipeline registers flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else if (state_reg == ST_INIT) begin
            if (init_cnt_reg == CW'(LAT)) begin
                state_reg <= ST_RUN;
            end else begin
                init_cnt_reg <= init_cnt_reg + CW'(1);
            end
        end
    end

    assign rsp_valid = tag_valid_reg[LAT];
    assign rsp_id    = tag_id_reg[LAT];
    assign rsp_p     = dsp_p;
    assign dsp_rst   = (state_reg == ST_INIT);
    assign ce        = (state_reg == ST_INIT) ? 1'b1 : !(rsp_valid && !rsp_ready);
    assign dsp_ce    = ce;

    // Rotating priority search starting at ptr_reg, wrapping modulo N_REQ.
    always_comb begin
        winner      = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_reg} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                winner      = cand[IDW-1:0];
            end
        end
    end

    assign transfer = (state_reg == ST_RUN) && ce && grant_found;
    assign ptr_next = (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = transfer && (winner == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (transfer) begin
            ptr_reg <= ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dsp_a_reg <= '0;
            dsp_b_reg <= '0;
            dsp_c_reg <= '0;
            dsp_d_reg <= '0;
        end else if (transfer) begin
            dsp_a_reg <= req_a[winner*30 +: 30];
            dsp_b_reg <= req_b[winner*18 +: 18];
            dsp_c_reg <= req_c[winner*48 +: 48];
            dsp_d_reg <= req_d[winner*25 +: 25];
        end
    end

    assign dsp_a = dsp_a_reg;
    assign dsp_b = dsp_b_reg;
    assign dsp_c = dsp_c_reg;
    assign dsp_d = dsp_d_reg;

    // Tag pipe mirrors the slice pipeline and freezes with it whenever ce is low.
    always_ff @(posedge clk) begin
        if (rst || (state_reg == ST_INIT)) begin
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= '0;
        end else if (ce) begin
            tag_valid_reg[0] <= transfer;
            tag_id_reg[0]    <= winner;
        end
    end

    generate
        for (genvar gi = 1; gi <= LAT; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (rst || (state_reg == ST_INIT)) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else if (ce) begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dsp_share_arb.sv
// Bench for dsp_share_arb: behavioural slice model, queue-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_dsp_share_arb;

    localparam int N_REQ = 4;
    localparam int LAT   = 3;
    localparam int IDW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*30-1:0]  req_a;
    logic [N_REQ*18-1:0]  req_b;
    logic [N_REQ*48-1:0]  req_c;
    logic [N_REQ*25-1:0]  req_d;
    logic [29:0]          dsp_a;
    logic [17:0]          dsp_b;
    logic [47:0]          dsp_c;
    logic [24:0]          dsp_d;
    logic                 dsp_ce;
    logic                 dsp_rst;
    logic [47:0]          dsp_p;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [47:0]          rsp_p;
    logic                 rsp_ready;

    dsp_share_arb #(.N_REQ(N_REQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_d(dsp_d),
        .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural DSP slice: P = A*B + C after LAT enabled edges.
    logic [47:0] slice_q [0:LAT-1];
    always @(posedge clk) begin
        if (dsp_rst) begin
            for (int k = 0; k < LAT; k++) slice_q[k] <= '0;
        end else if (dsp_ce) begin
            slice_q[0] <= 48'(dsp_a) * 48'(dsp_b) + dsp_c;
            for (int k = 1; k < LAT; k++) slice_q[k] <= slice_q[k-1];
        end
    end
    assign dsp_p = slice_q[LAT-1];

    typedef struct {
        int          id;
        logic [47:0] p;
        int          age;
    } item_t;

    item_t       q[$];
    bit          armed = 1'b0;
    bit          m_run = 1'b0;
    int          m_cnt = 0;
    int          m_ptr = 0;
    int          grant_ids[$];
    int          grant_cyc[$];
    int          rsp_ids[$];
    logic [47:0] rsp_ps[$];
    int          rsp_cyc[$];

    // Reference model: in-flight items age on enabled edges; head shows at age LAT.
    always @(negedge clk) begin : cmp
        bit               ev;
        bit               ece;
        logic [N_REQ-1:0] erdy;
        int               win;
        int               idx;
        item_t            it;
        logic [29:0]      a;
        logic [17:0]      b;
        logic [47:0]      c;
        ev   = 1'b0;
        ece  = 1'b1;
        erdy = '0;
        win  = -1;
        if (armed) begin
            ev  = m_run && (q.size() > 0) && (q[0].age == LAT);
            ece = m_run ? !(ev && !rsp_ready) : 1'b1;
            if (m_run && ece) begin
                for (int k = 0; k < N_REQ; k++) begin
                    idx = (m_ptr + k) % N_REQ;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            if (win >= 0) erdy[win] = 1'b1;
            chk("dsp_rst", 64'(dsp_rst), 64'(!m_run));
            chk("dsp_ce", 64'(dsp_ce), 64'(ece));
            chk("req_ready", 64'(req_ready), 64'(erdy));
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (ev) begin
                chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                chk("rsp_p", 64'(rsp_p), 64'(q[0].p));
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    grant_ids.push_back(k);
                    grant_cyc.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_ids.push_back(int'(rsp_id));
                rsp_ps.push_back(rsp_p);
                rsp_cyc.push_back(cyc);
                $display("[TB] rsp id=%0d p=%h cycle=%0d", rsp_id, rsp_p, cyc);
            end
        end
        if (rst) begin
            m_run = 1'b0;
            m_cnt = 0;
            m_ptr = 0;
            q.delete();
            armed = 1'b1;
        end else if (armed && !m_run) begin
            if (m_cnt == LAT) m_run = 1'b1;
            else m_cnt++;
        end else if (armed && m_run && ece) begin
            if (ev && rsp_ready) void'(q.pop_front());
            for (int k = 0; k < q.size(); k++) begin
                it = q[k];
                it.age++;
                q[k] = it;
            end
            if (win >= 0) begin
                a = req_a[win*30 +: 30];
                b = req_b[win*18 +: 18];
                c = req_c[win*48 +: 48];
                it.id  = win;
                it.p   = 48'(a) * 48'(b) + c;
                it.age = 0;
                q.push_back(it);
                m_ptr = (win + 1) % N_REQ;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [29:0] a, input logic [17:0] b,
                           input logic [47:0] c, input logic [24:0] d);
        req_a[i*30 +: 30] = a;
        req_b[i*18 +: 18] = b;
        req_c[i*48 +: 48] = c;
        req_d[i*25 +: 25] = d;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N_REQ; i++) begin
            set_ops(i, 30'($urandom), 18'($urandom), 48'({$urandom, $urandom}), 25'($urandom));
        end
    endtask

    task automatic run_grants(input int target, input logic [N_REQ-1:0] mask);
        int n;
        n = 0;
        req_valid = mask;
        while (grant_ids.size() < target && n < 40) begin
            rand_ops();
            step();
            n++;
        end
        req_valid = '0;
        chk("grant_count", 64'(grant_ids.size()), 64'(target));
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n;
        n = 0;
        while (rsp_ids.size() < target && n < budget) begin
            step();
            n++;
        end
        chk("rsp_count", 64'(rsp_ids.size()), 64'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int gb;
        int rb;
        int n;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;

        // Init sequence combined with a single operation from requester 2.
        step();
        step();
        rst = 1'b0;
        c1  = cyc;
        set_ops(2, 30'd3, 18'd5, 48'd7, 25'd0);
        req_valid = 4'b0100;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'h0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset_rsp_id", 64'(rsp_id), 64'h0);
        chk("reset_dsp_a", 64'(dsp_a), 64'h0);
        chk("reset_dsp_b", 64'(dsp_b), 64'h0);
        chk("reset_dsp_c", 64'(dsp_c), 64'h0);
        chk("reset_dsp_d", 64'(dsp_d), 64'h0);
        chk("reset_dsp_ce", 64'(dsp_ce), 64'h1);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) #1;
            chk("init_dsp_rst", 64'(dsp_rst), 64'h1);
            chk("init_req_ready", 64'(req_ready), 64'h0);
            step();
        end
        #1;
        chk("run_dsp_rst", 64'(dsp_rst), 64'h0);
        chk("first_grant", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        wait_rsp(1, 20);
        chk("single_grant_cycle", 64'(grant_cyc[0]), 64'(c1 + 4));
        chk("single_rsp_id", 64'(rsp_ids[0]), 64'd2);
        chk("single_rsp_p", 64'(rsp_ps[0]), 64'd22);
        chk("single_rsp_cycle", 64'(rsp_cyc[0]), 64'(c1 + 8));

        // Fairness: all requesters valid from ptr=0 after a fresh reset.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        gb = grant_ids.size();
        rb = rsp_ids.size();
        run_grants(gb + 8, 4'b1111);
        for (int k = 0; k < 8; k++) chk("fair_grant", 64'(grant_ids[gb+k]), 64'(k % 4));
        wait_rsp(rb + 8, 30);
        for (int k = 0; k < 8; k++) chk("fair_rsp_id", 64'(rsp_ids[rb+k]), 64'(k % 4));

        // Backpressure: stall the first of three results for five cycles.
        gb = grant_ids.size();
        rb = rsp_ids.size();
        run_grants(gb + 3, 4'b0111);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp_first_valid", 64'(rsp_valid), 64'h1);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_dsp_ce", 64'(dsp_ce), 64'h0);
            chk("bp_req_ready", 64'(req_ready), 64'h0);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        wait_rsp(rb + 3, 20);
        repeat (6) step();
        chk("bp_rsp_total", 64'(rsp_ids.size()), 64'(rb + 3));
        for (int k = 0; k < 3; k++) chk("bp_rsp_id", 64'(rsp_ids[rb+k]), 64'(k));

        // Reset with three operations in flight.
        gb = grant_ids.size();
        run_grants(gb + 3, 4'b0111);
        rst = 1'b1;
        step();
        rst = 1'b0;
        c1 = cyc;
        gb = grant_ids.size();
        rb = rsp_ids.size();
        run_grants(gb + 1, 4'b0010);
        chk("mid_grant_cycle", 64'(grant_cyc[gb]), 64'(c1 + 4));
        chk("mid_grant_id", 64'(grant_ids[gb]), 64'd1);
        wait_rsp(rb + 1, 20);
        chk("mid_rsp_id", 64'(rsp_ids[rb]), 64'd1);
        chk("mid_rsp_cycle", 64'(rsp_cyc[rb]), 64'(grant_cyc[gb] + 4));
        repeat (6) step();
        chk("mid_rsp_total", 64'(rsp_ids.size()), 64'(rb + 1));

        // Sparse wrap: move ptr to 1, then only requesters 3 and 0 valid.
        gb = grant_ids.size();
        rb = rsp_ids.size();
        run_grants(gb + 1, 4'b0001);
        run_grants(gb + 4, 4'b1001);
        chk("wrap_grant0", 64'(grant_ids[gb+1]), 64'd3);
        chk("wrap_grant1", 64'(grant_ids[gb+2]), 64'd0);
        chk("wrap_grant2", 64'(grant_ids[gb+3]), 64'd3);
        wait_rsp(rb + 4, 20);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
